// File: rtl/alu_pkg.sv
// Shared opcode tags, result-stage state encodings and the flag derivation rule
// used by the ALU result stage.
package alu_pkg;

    localparam int OPW = 4;

    localparam logic [OPW-1:0] OP_ADD = 4'd0;
    localparam logic [OPW-1:0] OP_SUB = 4'd1;
    localparam logic [OPW-1:0] OP_AND = 4'd2;
    localparam logic [OPW-1:0] OP_OR  = 4'd3;
    localparam logic [OPW-1:0] OP_XOR = 4'd4;
    localparam logic [OPW-1:0] OP_NOT = 4'd5;
    localparam logic [OPW-1:0] OP_SLL = 4'd6;
    localparam logic [OPW-1:0] OP_SRL = 4'd7;
    localparam logic [OPW-1:0] OP_SRA = 4'd8;
    localparam logic [OPW-1:0] OP_ROL = 4'd9;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    typedef struct packed {
        logic zero;
        logic neg;
        logic carry;
        logic ovf;
    } flags_t;

    // Width-independent: the caller supplies the zero test and the sign bits.
    function automatic flags_t calc_flags(
        input logic [OPW-1:0] op,
        input logic           s_zero,
        input logic           s_msb,
        input logic           cout,
        input logic           a_msb,
        input logic           b_msb
    );
        flags_t f;
        f.zero  = s_zero;
        f.neg   = s_msb;
        f.carry = 1'b0;
        f.ovf   = 1'b0;
        if (op == OP_ADD) begin
            f.carry = cout;
            f.ovf   = (a_msb == b_msb) && (s_msb != a_msb);
        end else if (op == OP_SUB) begin
            f.carry = cout;
            f.ovf   = (a_msb != b_msb) && (s_msb != a_msb);
        end
        return f;
    endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational zero/negative/carry/overflow derivation for one ALU result beat.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] s,
    input  logic [OPW-1:0]   op,
    input  logic             cout,
    input  logic             a_msb,
    input  logic             b_msb,
    output flags_t           flags
);

    always_comb begin
        flags = calc_flags(op, (s == '0), s[WIDTH-1], cout, a_msb, b_msb);
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU output stage: main/skid two-entry buffer behind a valid/ready
// handshake, with flags captured at accept time and a sticky overflow bit.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int OPW   = alu_pkg::OPW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_s,
    input  logic             in_cout,
    input  logic [OPW-1:0]   in_op,
    input  logic             in_a_msb,
    input  logic             in_b_msb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [OPW-1:0]   out_op,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_carry,
    output logic             out_ovf,
    input  logic             clr_sticky,
    output logic             sticky_ovf
);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [OPW-1:0]   op;
        flags_t           flags;
    } entry_t;

    state_e state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   sticky_q, sticky_d;

    flags_t in_flags;
    entry_t in_entry;
    logic   accept;
    logic   deliver;

    alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
        .s     (in_s),
        .op    (in_op),
        .cout  (in_cout),
        .a_msb (in_a_msb),
        .b_msb (in_b_msb),
        .flags (in_flags)
    );

    // Both handshake qualifiers come from the state register only.
    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid && in_ready;
    assign deliver   = out_valid && out_ready;

    always_comb begin
        in_entry.result = in_s;
        in_entry.op     = in_op;
        in_entry.flags  = in_flags;
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_d  = in_entry;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && !deliver) begin
                    skid_d  = in_entry;
                    state_d = ST_FULL;
                end else if (deliver && !accept) begin
                    state_d = ST_EMPTY;
                end else if (accept && deliver) begin
                    main_d  = in_entry;
                end
            end
            ST_FULL: begin
                if (deliver) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // A set in the same cycle as a clear wins.
    always_comb begin
        sticky_d = (sticky_q && !clr_sticky) || (accept && in_flags.ovf);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            main_q   <= '0;
            skid_q   <= '0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
            sticky_q <= sticky_d;
        end
    end

    assign out_result = main_q.result;
    assign out_op     = main_q.op;
    assign out_zero   = main_q.flags.zero;
    assign out_neg    = main_q.flags.neg;
    assign out_carry  = main_q.flags.carry;
    assign out_ovf    = main_q.flags.ovf;
    assign sticky_ovf = sticky_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: a queue-based reference model of the
// two-deep FIFO stage checked every cycle, plus hand-computed literal checks.
module tb_alu_result_stage;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_s;
    logic          in_cout;
    logic [3:0]    in_op;
    logic          in_a_msb;
    logic          in_b_msb;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic [3:0]    out_op;
    logic          out_zero;
    logic          out_neg;
    logic          out_carry;
    logic          out_ovf;
    logic          clr_sticky;
    logic          sticky_ovf;

    alu_result_stage #(.WIDTH(W), .OPW(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_s       (in_s),
        .in_cout    (in_cout),
        .in_op      (in_op),
        .in_a_msb   (in_a_msb),
        .in_b_msb   (in_b_msb),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_op     (out_op),
        .out_zero   (out_zero),
        .out_neg    (out_neg),
        .out_carry  (out_carry),
        .out_ovf    (out_ovf),
        .clr_sticky (clr_sticky),
        .sticky_ovf (sticky_ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [W-1:0] result;
        logic [3:0]   op;
        logic         zero, neg, carry, ovf;
    } exp_t;

    exp_t         model_q[$];
    logic         model_sticky = 1'b0;
    logic [W-1:0] delivered[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t predict(input logic [W-1:0] s, input logic cout, input logic [3:0] op,
                                     input logic a, input logic b);
        exp_t e;
        logic sm;
        sm       = s[W-1];
        e.result = s;
        e.op     = op;
        e.zero   = (s == 0);
        e.neg    = sm;
        e.carry  = (op == 4'd0 || op == 4'd1) ? cout : 1'b0;
        if (op == 4'd0)      e.ovf = (a == b) && (sm != a);
        else if (op == 4'd1) e.ovf = (a != b) && (sm != a);
        else                 e.ovf = 1'b0;
        return e;
    endfunction

    always @(negedge rst_n) begin
        model_q.delete();
        model_sticky = 1'b0;
    end

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            model_q.delete();
            model_sticky = 1'b0;
        end else begin
            automatic bit acc = in_valid && (model_q.size() < 2);
            automatic bit del = out_ready && (model_q.size() > 0);
            automatic exp_t e = predict(in_s, in_cout, in_op, in_a_msb, in_b_msb);
            model_sticky = (model_sticky && !clr_sticky) || (acc && e.ovf);
            if (del) begin
                delivered.push_back(model_q[0].result);
                void'(model_q.pop_front());
            end
            if (acc) model_q.push_back(e);
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 1);
            chk("rst_result", out_result, 0);
            chk("rst_flags", {out_zero, out_neg, out_carry, out_ovf}, 0);
            chk("rst_sticky", sticky_ovf, 0);
        end else begin
            chk("out_valid", out_valid, model_q.size() > 0);
            chk("in_ready", in_ready, model_q.size() < 2);
            chk("sticky_ovf", sticky_ovf, model_sticky);
            if (model_q.size() > 0) begin
                chk("out_result", out_result, model_q[0].result);
                chk("out_op", out_op, model_q[0].op);
                chk("out_flags", {out_zero, out_neg, out_carry, out_ovf},
                    {model_q[0].zero, model_q[0].neg, model_q[0].carry, model_q[0].ovf});
            end
        end
    end

    // Presents a beat and waits for it to be accepted; in_valid stays high so
    // consecutive calls stream back to back.
    task automatic send(input logic [W-1:0] s, input logic cout, input logic [3:0] op,
                        input logic a, input logic b);
        int n = 0;
        logic rdy;
        in_valid = 1'b1;
        in_s     = s;
        in_cout  = cout;
        in_op    = op;
        in_a_msb = a;
        in_b_msb = b;
        forever begin
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout actual=stalled required=accepted");
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int c0;
        rst_n      = 1'b0;
        in_valid   = 1'b1;
        in_s       = 16'hABCD;
        in_cout    = 1'b1;
        in_op      = 4'd0;
        in_a_msb   = 1'b0;
        in_b_msb   = 1'b0;
        out_ready  = 1'b0;
        clr_sticky = 1'b0;

        // 1: reset with in_valid high
        repeat (3) @(posedge clk);
        #1;
        chk("t1_out_valid", out_valid, 0);
        chk("t1_in_ready", in_ready, 1);
        in_valid = 1'b0;
        rst_n = 1'b1;
        idle(2);

        // 2: ADD 0x7FFF + 0x0001
        send(16'h8000, 1'b0, 4'd0, 1'b0, 1'b0);
        in_valid = 1'b0;
        chk("t2_valid", out_valid, 1);
        chk("t2_result", out_result, 16'h8000);
        chk("t2_flags_znco", {out_zero, out_neg, out_carry, out_ovf}, 4'b0101);
        chk("t2_sticky", sticky_ovf, 1);
        out_ready = 1'b1;
        idle(1);
        clr_sticky = 1'b1;
        idle(1);
        clr_sticky = 1'b0;

        // 3: SLL of zero with cout set
        send(16'h0000, 1'b1, 4'd6, 1'b1, 1'b0);
        in_valid = 1'b0;
        chk("t3_flags_znco", {out_zero, out_neg, out_carry, out_ovf}, 4'b1000);
        idle(1);

        // extra patterns: SUB overflow with carry, undefined opcode
        send(16'h7FFF, 1'b1, 4'd1, 1'b1, 1'b0);
        send(16'hF00F, 1'b1, 4'hC, 1'b0, 1'b0);
        send(16'h1234, 1'b0, 4'd1, 1'b0, 1'b0);
        idle(3);
        clr_sticky = 1'b1;
        idle(1);
        clr_sticky = 1'b0;

        // 4: backpressure
        out_ready = 1'b0;
        send(16'h1111, 1'b0, 4'd2, 1'b0, 1'b0);
        send(16'h2222, 1'b0, 4'd3, 1'b0, 1'b0);
        in_s = 16'h3333;
        in_op = 4'd4;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("t4_in_ready_full", in_ready, 0);
        chk("t4_head_held", out_result, 16'h1111);
        delivered.delete();
        out_ready = 1'b1;
        send(16'h3333, 1'b0, 4'd4, 1'b0, 1'b0);
        idle(4);
        chk("t4_count", delivered.size(), 3);
        if (delivered.size() == 3) begin
            chk("t4_order0", delivered[0], 16'h1111);
            chk("t4_order1", delivered[1], 16'h2222);
            chk("t4_order2", delivered[2], 16'h3333);
        end

        // 5: streaming 100 beats
        delivered.delete();
        c0 = cyc;
        for (int i = 0; i < 100; i++)
            send(16'(i * 16'h0101), 1'(i % 2), 4'(i % 10), 1'(i % 3 == 0), 1'(i % 5 == 0));
        chk("t5_cycles", cyc - c0, 100);
        idle(3);
        chk("t5_delivered", delivered.size(), 100);

        // 6: sticky set vs clear, then reset while FULL
        send(16'h8000, 1'b0, 4'd0, 1'b0, 1'b0);
        in_valid = 1'b0;
        chk("t6_sticky_set", sticky_ovf, 1);
        clr_sticky = 1'b1;
        send(16'h8001, 1'b0, 4'd0, 1'b0, 1'b0);
        in_valid = 1'b0;
        clr_sticky = 1'b0;
        chk("t6_set_wins", sticky_ovf, 1);
        clr_sticky = 1'b1;
        idle(1);
        clr_sticky = 1'b0;
        chk("t6_clr_alone", sticky_ovf, 0);
        idle(2);
        out_ready = 1'b0;
        send(16'hAAAA, 1'b0, 4'd2, 1'b0, 1'b0);
        send(16'hBBBB, 1'b0, 4'd2, 1'b0, 1'b0);
        in_valid = 1'b0;
        chk("t6_full", in_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_ready", in_ready, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        out_ready = 1'b1;
        idle(3);
        chk("t6_post_rst_valid", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
